// File: rtl/sel_mode_n.sv
// sel_mode_n: parametrised key-driven mode selector.
//   A key press (debounce strobe with the key level low) arms a candidate
//   mode. The candidate commits once the key has been held for HOLD_CYC
//   cycles. A lockout of LOCK_CYC cycles follows each commit. sel_en gates
//   the acceptance of new presses and aborts a pending hold.
// Ports:
//   clk        - system clock
//   rst        - synchronous, active-high reset
//   key_value  - debounced key levels, 0 = pressed
//   key_flag   - one-cycle debounce-valid strobes, one per key
//   sel_en     - 1 = mode changes permitted
//   sel_type   - current committed mode (key i selects mode i)
//   mode_chg   - one-cycle pulse when sel_type changes value
//   busy       - high while arming or locked out
module sel_mode_n #(
    parameter int unsigned N_KEYS   = 4,
    parameter int unsigned MODE_W   = 2,
    parameter int unsigned RST_MODE = 0,
    parameter int unsigned HOLD_CYC = 3,
    parameter int unsigned LOCK_CYC = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_value,
    input  logic [N_KEYS-1:0] key_flag,
    input  logic              sel_en,
    output logic [MODE_W-1:0] sel_type,
    output logic              mode_chg,
    output logic              busy
);

    localparam int unsigned CNT_MAX = (HOLD_CYC > LOCK_CYC) ? HOLD_CYC : LOCK_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'((LOCK_CYC > 0) ? LOCK_CYC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        LOCK
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MODE_W-1:0] cand_q, cand_d;
    logic [MODE_W-1:0] sel_q, sel_d;
    logic              chg_q, chg_d;

    logic [N_KEYS-1:0] press;
    logic              found;
    logic [MODE_W-1:0] win;
    logic              cand_held;
    logic              commit;
    logic [MODE_W-1:0] commit_val;

    always_comb begin
        press = key_flag & ~key_value;

        // Lowest-index press wins; the rest are dropped.
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (press[i] && !found) begin
                found = 1'b1;
                win   = MODE_W'(i);
            end
        end

        cand_held = 1'b0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (cand_q == MODE_W'(i)) cand_held = ~key_value[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        sel_d      = sel_q;
        chg_d      = 1'b0;
        commit     = 1'b0;
        commit_val = cand_q;

        case (state_q)
            IDLE: begin
                if (sel_en && found) begin
                    cand_d = win;
                    if (HOLD_CYC == 0) begin
                        // Zero hold: the fresh winner commits on this edge.
                        commit     = 1'b1;
                        commit_val = win;
                    end else begin
                        state_d = ARM;
                        cnt_d   = '0;
                    end
                end
            end
            ARM: begin
                if (!sel_en || !cand_held) begin
                    state_d = IDLE;
                end else if (cnt_q == HOLD_LAST) begin
                    commit = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOCK: begin
                if (cnt_q == LOCK_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            sel_d = commit_val;
            chg_d = (commit_val != sel_q);
            if (LOCK_CYC > 0) begin
                state_d = LOCK;
                cnt_d   = '0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            sel_q   <= MODE_W'(RST_MODE);
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            sel_q   <= sel_d;
            chg_q   <= chg_d;
        end
    end

    assign sel_type = sel_q;
    assign mode_chg = chg_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sel_mode_n.sv
// tb_sel_mode_n: drives two selector instances from one stimulus stream.
//   Instance A: default parameters (4 keys, hold 3, lock 5).
//   Instance B: 8 keys, 3-bit mode, reset mode 5, zero hold, zero lock.
//   A deadline/countdown reference model predicts both instances.
module tb_sel_mode_n;

    logic       clk;
    logic [7:0] kv;
    logic [7:0] kf;
    logic       en;
    logic       rs;

    logic [1:0] sel_a;
    logic       chg_a, busy_a;
    logic [2:0] sel_b;
    logic       chg_b, busy_b;

    int n_cmp;
    int n_err;

    sel_mode_n #(
        .N_KEYS  (4),
        .MODE_W  (2),
        .RST_MODE(0),
        .HOLD_CYC(3),
        .LOCK_CYC(5)
    ) u_a (
        .clk      (clk),
        .rst      (rs),
        .key_value(kv[3:0]),
        .key_flag (kf[3:0]),
        .sel_en   (en),
        .sel_type (sel_a),
        .mode_chg (chg_a),
        .busy     (busy_a)
    );

    sel_mode_n #(
        .N_KEYS  (8),
        .MODE_W  (3),
        .RST_MODE(5),
        .HOLD_CYC(0),
        .LOCK_CYC(0)
    ) u_b (
        .clk      (clk),
        .rst      (rs),
        .key_value(kv),
        .key_flag (kf),
        .sel_en   (en),
        .sel_type (sel_b),
        .mode_chg (chg_b),
        .busy     (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one entry per instance.
    longint now;
    int     m_mode  [2];
    bit     m_chg   [2];
    bit     m_armed [2];
    int     m_cand  [2];
    longint m_dead  [2];
    int     m_lock  [2];

    task automatic model_edge(input int d, input int nk, input int hold, input int lock,
                              input int rmode, input logic [7:0] v, input logic [7:0] f);
        bit do_commit;
        int w;
        do_commit = 0;
        m_chg[d]  = 0;
        if (rs) begin
            m_mode[d] = rmode; m_armed[d] = 0; m_lock[d] = 0; m_cand[d] = 0;
        end else if (m_lock[d] > 0) begin
            m_lock[d]--;
        end else if (m_armed[d]) begin
            if (!en || v[m_cand[d]]) m_armed[d] = 0;
            else if (now == m_dead[d]) do_commit = 1;
        end else if (en) begin
            w = -1;
            for (int i = nk - 1; i >= 0; i--) if (f[i] && !v[i]) w = i;
            if (w >= 0) begin
                m_cand[d] = w;
                if (hold == 0) do_commit = 1;
                else begin m_armed[d] = 1; m_dead[d] = now + hold; end
            end
        end
        if (do_commit) begin
            m_chg[d]   = (m_cand[d] != m_mode[d]);
            m_mode[d]  = m_cand[d];
            m_armed[d] = 0;
            m_lock[d]  = lock;
        end
    endtask

    task automatic step(input logic [7:0] v, input logic [7:0] f, input logic e, input logic r);
        kv = v; kf = f; en = e; rs = r;
        @(posedge clk);
        now++;
        model_edge(0, 4, 3, 5, 0, {4'hF, v[3:0]}, {4'h0, f[3:0]});
        model_edge(1, 8, 0, 0, 5, v, f);
        #1;
        kf = 8'h00;
    endtask

    function automatic logic [3:0] obs_a();
        return {sel_a, chg_a, busy_a};
    endfunction
    function automatic logic [3:0] exp_a();
        return {2'(m_mode[0]), m_chg[0], (m_armed[0] || m_lock[0] > 0)};
    endfunction
    function automatic logic [4:0] obs_b();
        return {sel_b, chg_b, busy_b};
    endfunction
    function automatic logic [4:0] exp_b();
        return {3'(m_mode[1]), m_chg[1], (m_armed[1] || m_lock[1] > 0)};
    endfunction

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step(8'hFB, 8'h04, 1'b1, 1'b1);
            n_cmp++;
            if ({sel_a, chg_a, busy_a} !== 4'b0000) begin
                n_err++; $display("FAIL reset_a c=%0d got %b want 0000", c, {sel_a, chg_a, busy_a});
            end
            n_cmp++;
            if ({sel_b, chg_b, busy_b} !== 5'b10100) begin
                n_err++; $display("FAIL reset_b c=%0d got %b want 10100", c, {sel_b, chg_b, busy_b});
            end
        end
        step(8'hFF, 8'h00, 1'b1, 1'b0);
        n_cmp++;
        if (obs_a() !== exp_a()) begin
            n_err++; $display("FAIL reset_idle_a got %b want %b", obs_a(), exp_a());
        end
    endtask

    task automatic test_confirm();
        for (int c = 0; c < 9; c++) begin
            step(8'hFB, (c == 0) ? 8'h04 : 8'h00, 1'b1, 1'b0);
            n_cmp++;
            if (obs_a() !== exp_a()) begin
                n_err++; $display("FAIL confirm_a c=%0d got %b want %b", c, obs_a(), exp_a());
            end
            n_cmp++;
            if (obs_b() !== exp_b()) begin
                n_err++; $display("FAIL confirm_b c=%0d got %b want %b", c, obs_b(), exp_b());
            end
            if (c == 2 || c == 3 || c == 4 || c == 7 || c == 8) begin
                n_cmp++;
                if ((c == 2 && {sel_a, chg_a, busy_a} !== 4'b0001) ||
                    (c == 3 && {sel_a, chg_a, busy_a} !== 4'b1011) ||
                    (c == 4 && {sel_a, chg_a, busy_a} !== 4'b1001) ||
                    (c == 7 && busy_a !== 1'b1) || (c == 8 && busy_a !== 1'b0)) begin
                    n_err++; $display("FAIL confirm_timing c=%0d got sel=%0d chg=%b busy=%b", c, sel_a, chg_a, busy_a);
                end
            end
        end
    endtask

    task automatic test_early_release();
        for (int c = 0; c < 4; c++) begin
            step((c == 0) ? 8'hFD : 8'hFF, (c == 0) ? 8'h02 : 8'h00, 1'b1, 1'b0);
            n_cmp++;
            if (obs_a() !== exp_a()) begin
                n_err++; $display("FAIL early_a c=%0d got %b want %b", c, obs_a(), exp_a());
            end
            n_cmp++;
            if (c >= 1 && {sel_a, chg_a, busy_a} !== 4'b1000) begin
                n_err++; $display("FAIL early_abort c=%0d got %b want 1000", c, {sel_a, chg_a, busy_a});
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int c = 0; c < 9; c++) begin
            step(8'hF5, (c == 0) ? 8'h0A : 8'h00, 1'b1, 1'b0);
            n_cmp++;
            if (obs_a() !== exp_a()) begin
                n_err++; $display("FAIL simul_a c=%0d got %b want %b", c, obs_a(), exp_a());
            end
            if (c == 3) begin
                n_cmp++;
                if (sel_a !== 2'd1) begin
                    n_err++; $display("FAIL simul_lowest got %0d want 1", sel_a);
                end
            end
        end
    endtask

    task automatic test_lockout();
        logic [7:0] v, f;
        for (int c = 0; c < 18; c++) begin
            v = (c < 5) ? 8'hFD : (c < 9) ? 8'hF5 : 8'hFE;
            f = (c == 0) ? 8'h02 : (c == 5 || c == 8) ? 8'h08 : (c == 9) ? 8'h01 : 8'h00;
            step(v, f, 1'b1, 1'b0);
            n_cmp++;
            if (obs_a() !== exp_a()) begin
                n_err++; $display("FAIL lock_a c=%0d got %b want %b", c, obs_a(), exp_a());
            end
            n_cmp++;
            if (obs_b() !== exp_b()) begin
                n_err++; $display("FAIL lock_b c=%0d got %b want %b", c, obs_b(), exp_b());
            end
            if (c == 6 || c == 8 || c == 9 || c == 12) begin
                n_cmp++;
                if ((c == 6 && {sel_a, busy_a} !== 3'b011) || (c == 8 && {sel_a, busy_a} !== 3'b010) ||
                    (c == 9 && busy_a !== 1'b1) || (c == 12 && sel_a !== 2'd0)) begin
                    n_err++; $display("FAIL lock_timing c=%0d got sel=%0d busy=%b", c, sel_a, busy_a);
                end
            end
        end
    endtask

    task automatic test_inhibit();
        logic [7:0] v, f;
        // Current mode is 0 here.
        for (int c = 0; c < 5; c++) begin
            v = (c == 0) ? 8'hFB : 8'hF7;
            f = (c == 0) ? 8'h04 : (c == 1) ? 8'h08 : 8'h00;
            step(v, f, (c == 1 || c >= 3), 1'b0);
            n_cmp++;
            if (obs_a() !== exp_a()) begin
                n_err++; $display("FAIL inhibit_a c=%0d got %b want %b", c, obs_a(), exp_a());
            end
            n_cmp++;
            if ((c == 1) ? (busy_a !== 1'b1) : ({sel_a, chg_a, busy_a} !== 4'b0000)) begin
                n_err++; $display("FAIL inhibit_state c=%0d got %b", c, {sel_a, chg_a, busy_a});
            end
        end
    endtask

    task automatic test_reselect();
        for (int c = 0; c < 9; c++) begin
            step(8'hFE, (c == 0) ? 8'h01 : 8'h00, 1'b1, 1'b0);
            n_cmp++;
            if (obs_a() !== exp_a()) begin
                n_err++; $display("FAIL resel_a c=%0d got %b want %b", c, obs_a(), exp_a());
            end
            n_cmp++;
            if (chg_a !== 1'b0 || sel_a !== 2'd0 || busy_a !== (c < 8)) begin
                n_err++; $display("FAIL resel_quiet c=%0d got %b", c, {sel_a, chg_a, busy_a});
            end
        end
    endtask

    task automatic test_sweep_b();
        for (int c = 0; c < 4; c++) begin
            step((c < 2) ? 8'h7F : 8'h5F, (c == 0) ? 8'h80 : (c == 2) ? 8'hA0 : 8'h00, 1'b1, 1'b0);
            n_cmp++;
            if (obs_b() !== exp_b()) begin
                n_err++; $display("FAIL sweep_b c=%0d got %b want %b", c, obs_b(), exp_b());
            end
            n_cmp++;
            if ((c == 0 && {sel_b, chg_b, busy_b} !== 5'b11110) ||
                (c == 1 && {sel_b, chg_b, busy_b} !== 5'b11100) ||
                (c == 2 && {sel_b, chg_b, busy_b} !== 5'b10110) ||
                (c == 3 && {sel_b, chg_b, busy_b} !== 5'b10100)) begin
                n_err++; $display("FAIL sweep_key c=%0d got %b", c, {sel_b, chg_b, busy_b});
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int c = 0; c < 3; c++) begin
            step(8'hFB, (c == 0) ? 8'h04 : 8'h00, 1'b1, (c == 2));
            n_cmp++;
            if (obs_a() !== exp_a()) begin
                n_err++; $display("FAIL midrst_a c=%0d got %b want %b", c, obs_a(), exp_a());
            end
        end
        n_cmp++;
        if ({sel_a, chg_a, busy_a, sel_b} !== 7'b0000101) begin
            n_err++; $display("FAIL midrst_forced got %b want 0000101", {sel_a, chg_a, busy_a, sel_b});
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        v = 8'hFF;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) v = 8'($urandom);
            step(v, 8'($urandom & $urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 63) == 0));
            n_cmp++;
            if (obs_a() !== exp_a()) begin
                n_err++; $display("FAIL rand_a c=%0d got %b want %b", c, obs_a(), exp_a());
            end
            n_cmp++;
            if (obs_b() !== exp_b()) begin
                n_err++; $display("FAIL rand_b c=%0d got %b want %b", c, obs_b(), exp_b());
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; now = 0;
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_chg[d] = 0; m_armed[d] = 0; m_cand[d] = 0; m_dead[d] = 0; m_lock[d] = 0;
        end
        kv = 8'hFF; kf = 8'h00; en = 1'b1; rs = 1'b1;
        test_reset();
        test_confirm();
        test_early_release();
        test_simultaneous();
        test_lockout();
        test_inhibit();
        test_reselect();
        test_sweep_b();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sel_mode_n.md
Name: sel_mode_n

Overview:
- Parametrised successor to the four-key mode selector on the smart-car control path.
- Accepts N debounced key channels: each key has a debounced level and a one-cycle valid strobe.
- A press becomes a new operating mode only after it is held for a confirm interval.
- After each commit, further presses are ignored for a lockout window. Mode changes can be globally inhibited, e.g. while the car is moving. Downstream motor/PWM logic uses sel_type and the mode_chg pulse.

Parameters:
- N_KEYS, 4: number of key channels, ≥2. Key i selects mode i.
- MODE_W, 2: width of sel_type. Must satisfy 2^MODE_W ≥ N_KEYS.
- RST_MODE, 0: sel_type value after reset. Must be < N_KEYS.
- HOLD_CYC, 3: number of cycles the key must stay low after the press strobe before the commit. 0 = commit at the strobe edge.
- LOCK_CYC, 5: number of cycles after a commit during which all presses are ignored. 0 = none.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_value  in  N_KEYS  debounced key levels, 0 = pressed.
- key_flag  in  N_KEYS  one-cycle debounce-valid strobes, one per key.
- sel_en  in  1  1 = mode changes permitted.
- sel_type  out  MODE_W  current committed mode.
- mode_chg  out  1  one-cycle pulse when sel_type changes value.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. The reset port follows the codebase's rst naming; no _n suffix, because the polarity is active-high.
- Reset values: sel_type = RST_MODE, mode_chg = 0, busy = 0, FSM = IDLE, counter = 0, candidate register = 0. rst asserted at any point (including mid-ARM or mid-LOCK) aborts the operation and forces these values at that edge.
- Press event for key i: key_flag[i] & ~key_value[i] sampled at a rising edge. Release strobes (key_value = 1) are ignored.
- FSM states: IDLE, ARM, LOCK. All outputs are registered.
- IDLE:
  - If sel_en = 1 and any press event is present, the lowest-index pressed key wins and is captured as cand.
  - If several events arrive on the same edge, only the lowest index is used; the others are discarded, not queued.
  - If HOLD_CYC > 0: go to ARM with cnt = 0.
  - If HOLD_CYC = 0: commit at this edge.
  - If sel_en = 0: all events are ignored.
- ARM, at each edge:
  - If sel_en = 0 or key_value[cand] = 1: abort to IDLE. sel_type is unchanged and mode_chg is not pulsed.
  - Else, if cnt = HOLD_CYC−1: commit.
  - Else: cnt increments.
  - Press events on any key, including cand, are ignored while in ARM.
  - Timing: for a strobe at edge k with the key held low, the commit happens at edge k+HOLD_CYC.
- Commit (performed on a single edge):
  - sel_type ← cand.
  - mode_chg = 1 for exactly one cycle if cand ≠ the old sel_type; otherwise mode_chg stays 0. Re-selecting the current mode is legal and silent.
  - Next state: LOCK with cnt = 0 if LOCK_CYC > 0, else IDLE.
- LOCK:
  - cnt increments each edge. When cnt = LOCK_CYC−1, go to IDLE.
  - All events are ignored and sel_en is ignored. LOCK lasts exactly LOCK_CYC cycles.
  - A press event on the edge that leaves LOCK is ignored. The first event that can be accepted is on the following edge.
- Counter width is sized to hold max(HOLD_CYC, LOCK_CYC) with no overflow. It is never compared beyond its terminal value.
- busy = 1 in ARM and LOCK.
- key_value bits for non-candidate keys have no effect outside IDLE.

Test Plan:
- Reset/default: assert rst for 2 cycles → sel_type = 0, mode_chg = 0, busy = 0. Strobes during rst are ignored.
- Confirmed select: strobe key 2 at edge k, hold low ≥3 cycles → sel_type = 2 at edge k+3. mode_chg is high for 1 cycle only. busy is high from k to k+8, then IDLE at edge k+8.
- Early release: strobe key 1, release after 1 cycle → return to IDLE, sel_type unchanged, no mode_chg.
- Simultaneous presses: strobe keys 3 and 1 on the same edge, both held → sel_type = 1.
- Lockout and inhibit:
  - Strobe key 3 two cycles after a commit → ignored; sel_type stays at the prior mode.
  - A strobe on the first edge after the IDLE return is accepted.
  - With sel_en = 0, strobe key 2 → no ARM, busy stays 0.
  - Dropping sel_en mid-ARM → abort.
- Reselect and parameter sweep:
  - Reselect of the current mode → sel_type unchanged, mode_chg stays 0, LOCK still entered.
  - Rerun the scenarios with N_KEYS = 8, MODE_W = 3, HOLD_CYC = 0, LOCK_CYC = 0 → key 7 commits at the strobe edge, sel_type = 7, and the FSM is immediately back in IDLE.
